branch_update_unit: RTL and testbench

BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

---
 rtl/branch_update_unit.sv | 110 +++++++++++
 tb/tb_branch_update_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/branch_update_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_update_unit                                                         |
// | Queues resolved conditional branches from retire and replays them in       |
// | order as predictor training updates; flags mispredicts with a one-cycle    |
// | pulse. Define BRANCH_STATS_EN to add saturating branch/mispredict counters.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_update_unit #(
  parameter int DEPTH     = 4,
  parameter int PHT_IDX_W = 7,
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ret_valid,
  output logic                 ret_ready,
  input  logic [PHT_IDX_W-1:0] ret_pht_index,
  input  logic [BHT_IDX_W-1:0] ret_bht_index,
  input  logic                 ret_pred_taken,
  input  logic                 ret_actual_taken,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [PHT_IDX_W-1:0] upd_pht_index,
  output logic [BHT_IDX_W-1:0] upd_bht_index,
  output logic                 upd_taken,
`ifdef BRANCH_STATS_EN
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts,
`endif
  output logic                 mispredict
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [PHT_IDX_W-1:0] r_pht_mem [DEPTH];
  logic [BHT_IDX_W-1:0] r_bht_mem [DEPTH];
  logic                 r_tkn_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_mispredict;

  logic w_push;
  logic w_pop;
  logic w_mispred;

  // Handshakes are gated by resetn so nothing is offered or taken while held in reset.
  assign ret_ready = resetn && (r_count != C_FULL);
  assign upd_valid = resetn && (r_count != '0);
  assign w_push    = ret_valid && ret_ready;
  assign w_pop     = upd_valid && upd_ready;
  assign w_mispred = w_push && (ret_pred_taken != ret_actual_taken);

  assign upd_pht_index = upd_valid ? r_pht_mem[r_rd_ptr] : '0;
  assign upd_bht_index = upd_valid ? r_bht_mem[r_rd_ptr] : '0;
  assign upd_taken     = upd_valid ? r_tkn_mem[r_rd_ptr] : 1'b0;
  assign mispredict    = r_mispredict;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pht_mem[r_wr_ptr] <= ret_pht_index;
      r_bht_mem[r_wr_ptr] <= ret_bht_index;
      r_tkn_mem[r_wr_ptr] <= ret_actual_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_mispredict <= 1'b0;
    end else begin
      r_mispredict <= w_mispred;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_push && (r_stat_branches != 32'hFFFF_FFFF))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispred && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_update_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_update_unit                                                      |
// | Scoreboard bench: accepted retires queue expectations, monitor compares.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_update_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ret_valid;
  logic       ret_ready;
  logic [6:0] ret_pht_index;
  logic [3:0] ret_bht_index;
  logic       ret_pred_taken;
  logic       ret_actual_taken;
  logic       upd_valid;
  logic       upd_ready;
  logic [6:0] upd_pht_index;
  logic [3:0] upd_bht_index;
  logic       upd_taken;
  logic       mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_update_unit #(.DEPTH(DEPTH), .PHT_IDX_W(7), .BHT_IDX_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_pht_index(ret_pht_index), .ret_bht_index(ret_bht_index),
    .ret_pred_taken(ret_pred_taken), .ret_actual_taken(ret_actual_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pht_index(upd_pht_index), .upd_bht_index(upd_bht_index),
    .upd_taken(upd_taken),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] pht;
    logic [3:0] bht;
    logic       taken;
  } ent_t;

  ent_t        exp_q[$];
  logic        exp_mis = 1'b0;
  bit          started = 1'b0;
  logic [31:0] exp_br  = '0;
  logic [31:0] exp_mp  = '0;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of accepted branches, bounded at DEPTH.
  always @(posedge clk) begin
    bit acc, pop;
    if (!resetn) begin
      exp_q.delete();
      exp_mis = 1'b0;
      exp_br  = '0;
      exp_mp  = '0;
      started = 1'b1;
    end else begin
      acc = ret_valid && (exp_q.size() != DEPTH);
      pop = upd_ready && (exp_q.size() != 0);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{ret_pht_index, ret_bht_index, ret_actual_taken});
      exp_mis = acc && (ret_pred_taken != ret_actual_taken);
      if (acc && exp_br != 32'hFFFF_FFFF) exp_br++;
      if (exp_mis && exp_mp != 32'hFFFF_FFFF) exp_mp++;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      if (!resetn) begin
        chk("ready_in_reset", {31'd0, ret_ready}, 32'd0);
        chk("valid_in_reset", {31'd0, upd_valid}, 32'd0);
        chk("upd_in_reset", {20'd0, upd_pht_index, upd_bht_index, upd_taken}, 32'd0);
      end else begin
        chk("ret_ready", {31'd0, ret_ready}, {31'd0, exp_q.size() != DEPTH});
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0)
          chk("upd_head", {20'd0, upd_pht_index, upd_bht_index, upd_taken},
              {20'd0, exp_q[0].pht, exp_q[0].bht, exp_q[0].taken});
        else
          chk("upd_idle_zero", {20'd0, upd_pht_index, upd_bht_index, upd_taken}, 32'd0);
      end
      chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mis});
`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, exp_br);
      chk("stat_mispredicts", stat_mispredicts, exp_mp);
`endif
    end
  end

  task automatic cyc(input logic v, input logic [6:0] p, input logic [3:0] b,
                     input logic pr, input logic ac, input logic ur, input logic rn);
    @(negedge clk);
    #1;
    ret_valid        = v;
    ret_pht_index    = p;
    ret_bht_index    = b;
    ret_pred_taken   = pr;
    ret_actual_taken = ac;
    upd_ready        = ur;
    resetn           = rn;
  endtask

  task automatic idle(input logic ur, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, ur, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; ret_valid = 1'b0; ret_pht_index = '0; ret_bht_index = '0;
    ret_pred_taken = 1'b0; ret_actual_taken = 1'b0; upd_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Single mispredicted branch: appears next cycle with a mispredict pulse.
    idle(1'b1, 1);
    cyc(1'b1, 7'h15, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 3);

    // Fill to DEPTH with the predictor stalled, offer one more, then drain.
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b1, 7'(8'h20 + i), 4'(i), i[0], 1'b1, 1'b0, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, DEPTH + 2);

    // Hold two entries, then stream push+pop across pointer wrap.
    for (int i = 0; i < 2; i++) cyc(1'b1, 7'(8'h40 + i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 7'(8'h50 + i), 4'(i + 5), 1'b1, i[1], 1'b1, 1'b1);
    idle(1'b1, 4);

    // Reset with three entries queued: all must be discarded.
    for (int i = 0; i < 3; i++) cyc(1'b1, 7'(8'h60 + i), 4'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Six accepted branches, two of them mispredicted.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 7'(i), 4'(i), 1'b1, (i >= 2), 1'b1, 1'b1);
    idle(1'b1, 3);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 60) != 0));
    idle(1'b1, DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
